// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared types for the systolic-array control units.
// Holds the per-array weight-load state and a selector-width helper.
package sys_arr_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        READY
    } gsau_arr_state_t;

    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gsau_multi_dispatch_if.sv
// gsau_multi_dispatch_if: scoreboard issue and writeback handshakes.
// master = scoreboard/writeback side, slave = the dispatcher.
interface gsau_multi_dispatch_if #(
    parameter int ENTRY_BITS = 8,
    parameter int SEL_BITS   = 1,
    parameter int DATA_W     = 64
);
    logic                  sb_valid;
    logic                  sb_ready;
    logic                  sb_weight;
    logic [SEL_BITS-1:0]   sb_array;
    logic [ENTRY_BITS-1:0] sb_vdst;
    logic                  wb_valid;
    logic                  wb_output_ready;
    logic [ENTRY_BITS-1:0] wb_wbdst;
    logic [DATA_W-1:0]     wb_psum;
    logic [SEL_BITS-1:0]   wb_array;

    modport master (
        output sb_valid, sb_weight, sb_array, sb_vdst,
        output wb_output_ready,
        input  sb_ready,
        input  wb_valid, wb_wbdst, wb_psum, wb_array
    );

    modport slave (
        input  sb_valid, sb_weight, sb_array, sb_vdst,
        input  wb_output_ready,
        output sb_ready,
        output wb_valid, wb_wbdst, wb_psum, wb_array
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the lowest requester at or after ptr,
// wrapping back to index 0.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);
    logic found;

    // First pass covers [ptr, N-1], second pass the wrapped [0, ptr-1].
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i >= int'(ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i < int'(ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear.
// Push is refused when full, even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int FIFODEPTH = 32,
    parameter int DATAWIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 clear,
    input  logic                 wen,
    input  logic                 ren,
    input  logic [DATAWIDTH-1:0] wdata,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 empty,
    output logic                 full
);
    localparam int PW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam int CW = $clog2(FIFODEPTH + 1);

    logic [DATAWIDTH-1:0] mem_q [FIFODEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFODEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy flags and next pointer/count values.
    always_comb begin
        empty  = (cnt_q == '0);
        full   = (cnt_q == CW'(FIFODEPTH));
        push   = wen && !full;
        pop    = ren && !empty;
        wptr_d = push ? inc(wptr_q) : wptr_q;
        rptr_d = pop ? inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
        rdata = mem_q[rptr_q];
    end

    // Storage array; no reset needed since reads are gated by empty.
    always_ff @(posedge CLK) begin
        if (push && !clear) mem_q[wptr_q] <= wdata;
    end

    // Pointer and count registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/gsau_multi_dispatch.sv
// gsau_multi_dispatch: steers weight rows and inputs to NUM_ARRAYS
// systolic arrays and round-robins their results onto one writeback.
module gsau_multi_dispatch
    import sys_arr_pkg::*;
#(
    parameter int VEGGIEREGS = 256,
    parameter int NUM_ARRAYS = 2,
    parameter int ARRAY_DIM  = 4,
    parameter int TAG_DEPTH  = 32,
    parameter int DATA_W     = 64,
    localparam int ENTRY_BITS = $clog2(VEGGIEREGS),
    localparam int SEL_BITS   = sel_bits(NUM_ARRAYS)
) (
    input  logic                         CLK,
    input  logic                         nRST,
    gsau_multi_dispatch_if.slave         bus,
    input  logic [DATA_W-1:0]            veg_vdata1,
    input  logic [DATA_W-1:0]            veg_vdata2,
    output logic [DATA_W-1:0]            sa_array_in,
    output logic [DATA_W-1:0]            sa_array_in_partials,
    output logic [NUM_ARRAYS-1:0]        sa_input_en,
    output logic [NUM_ARRAYS-1:0]        sa_partial_en,
    output logic [NUM_ARRAYS-1:0]        sa_weight_en,
    output logic                         sa_flush,
    input  logic [NUM_ARRAYS-1:0]        sa_fifo_has_space,
    input  logic [NUM_ARRAYS-1:0]        sa_out_valid,
    input  logic [NUM_ARRAYS*DATA_W-1:0] sa_array_output,
    output logic [NUM_ARRAYS-1:0]        sa_output_ready,
    input  logic                         flush,
    output logic [NUM_ARRAYS-1:0]        weights_ready,
    output logic                         err_orphan
);
    localparam int CNT_W = $clog2(ARRAY_DIM + 1);

    gsau_arr_state_t state_q [NUM_ARRAYS];
    gsau_arr_state_t state_d [NUM_ARRAYS];
    logic [CNT_W-1:0] cnt_q [NUM_ARRAYS];
    logic [CNT_W-1:0] cnt_d [NUM_ARRAYS];
    logic [SEL_BITS-1:0] rr_q, rr_d;
    logic err_q, err_d;
    logic [NUM_ARRAYS-1:0] fifo_empty, fifo_full;
    logic [NUM_ARRAYS-1:0] hit, acc_ok, req, grant;
    logic [ENTRY_BITS-1:0] fifo_rdata [NUM_ARRAYS];
    logic fire;

    assign sa_array_in          = veg_vdata1;
    assign sa_array_in_partials = veg_vdata2;
    assign sa_flush             = nRST && flush;
    assign err_orphan           = err_q;

    // Issue acceptance: only the addressed array decides sb_ready.
    always_comb begin
        for (int i = 0; i < NUM_ARRAYS; i++) begin
            hit[i]    = (SEL_BITS'(i) == bus.sb_array);
            acc_ok[i] = bus.sb_weight ? fifo_empty[i]
                      : (state_q[i] == READY && !fifo_full[i]
                         && sa_fifo_has_space[i]);
        end
        bus.sb_ready  = nRST && !flush && |(hit & acc_ok);
        fire          = bus.sb_valid && bus.sb_ready;
        sa_weight_en  = (fire && bus.sb_weight) ? hit : '0;
        sa_input_en   = (fire && !bus.sb_weight) ? hit : '0;
        sa_partial_en = sa_input_en;
    end

    // Per-array weight-load progress.
    always_comb begin
        for (int i = 0; i < NUM_ARRAYS; i++) begin
            state_d[i]       = state_q[i];
            cnt_d[i]         = cnt_q[i];
            weights_ready[i] = (state_q[i] == READY);
            if (flush) begin
                state_d[i] = EMPTY;
                cnt_d[i]   = '0;
            end else if (sa_weight_en[i]) begin
                if (state_q[i] == LOADING) begin
                    if (cnt_q[i] == CNT_W'(ARRAY_DIM - 1)) begin
                        state_d[i] = READY;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else if (ARRAY_DIM == 1) begin
                    state_d[i] = READY;
                    cnt_d[i]   = '0;
                end else begin
                    state_d[i] = LOADING;
                    cnt_d[i]   = CNT_W'(1);
                end
            end
        end
    end

    assign req = flush ? '0 : (sa_out_valid & ~fifo_empty);

    rr_arbiter #(
        .N  (NUM_ARRAYS),
        .PW (SEL_BITS)
    ) u_wb_arb (
        .req   (req),
        .ptr   (rr_q),
        .grant (grant)
    );

    // Writeback mux, pointer advance and orphan detection.
    always_comb begin
        bus.wb_valid    = |grant;
        bus.wb_wbdst    = '0;
        bus.wb_psum     = '0;
        bus.wb_array    = '0;
        rr_d            = rr_q;
        sa_output_ready = grant & {NUM_ARRAYS{bus.wb_output_ready}};
        err_d           = err_q | |(sa_out_valid & fifo_empty);
        for (int i = 0; i < NUM_ARRAYS; i++) begin
            if (grant[i]) begin
                bus.wb_wbdst = fifo_rdata[i];
                bus.wb_psum  = sa_array_output[i*DATA_W +: DATA_W];
                bus.wb_array = SEL_BITS'(i);
                if (bus.wb_output_ready) begin
                    rr_d = (i == NUM_ARRAYS - 1) ? '0
                         : SEL_BITS'(i + 1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_ARRAYS; g++) begin : g_fifo
        sync_fifo #(
            .FIFODEPTH (TAG_DEPTH),
            .DATAWIDTH (ENTRY_BITS)
        ) u_fifo (
            .CLK   (CLK),
            .nRST  (nRST),
            .clear (flush),
            .wen   (sa_input_en[g]),
            .ren   (sa_output_ready[g]),
            .wdata (bus.sb_vdst),
            .rdata (fifo_rdata[g]),
            .empty (fifo_empty[g]),
            .full  (fifo_full[g])
        );
    end

    // Array state, row counters, round-robin pointer, sticky error.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_ARRAYS; i++) begin
                state_q[i] <= EMPTY;
                cnt_q[i]   <= '0;
            end
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ARRAYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_gsau_multi_dispatch.sv
// tb_gsau_multi_dispatch: directed and random traffic checked each
// cycle against a queue-based model of the dispatcher.
module tb_gsau_multi_dispatch;
    localparam int NA = 2;
    localparam int AD = 4;
    localparam int TD = 32;
    localparam int DW = 64;
    localparam int EB = 8;
    localparam int SB = 1;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    gsau_multi_dispatch_if #(
        .ENTRY_BITS (EB),
        .SEL_BITS   (SB),
        .DATA_W     (DW)
    ) bus ();

    logic [DW-1:0]    veg_vdata1, veg_vdata2;
    logic [DW-1:0]    sa_array_in, sa_array_in_partials;
    logic [NA-1:0]    sa_input_en, sa_partial_en, sa_weight_en;
    logic [NA-1:0]    sa_fifo_has_space, sa_out_valid;
    logic [NA-1:0]    sa_output_ready, weights_ready;
    logic [NA*DW-1:0] sa_array_output;
    logic             sa_flush, flush, err_orphan;

    gsau_multi_dispatch #(
        .VEGGIEREGS (256),
        .NUM_ARRAYS (NA),
        .ARRAY_DIM  (AD),
        .TAG_DEPTH  (TD),
        .DATA_W     (DW)
    ) dut (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .bus                  (bus),
        .veg_vdata1           (veg_vdata1),
        .veg_vdata2           (veg_vdata2),
        .sa_array_in          (sa_array_in),
        .sa_array_in_partials (sa_array_in_partials),
        .sa_input_en          (sa_input_en),
        .sa_partial_en        (sa_partial_en),
        .sa_weight_en         (sa_weight_en),
        .sa_flush             (sa_flush),
        .sa_fifo_has_space    (sa_fifo_has_space),
        .sa_out_valid         (sa_out_valid),
        .sa_array_output      (sa_array_output),
        .sa_output_ready      (sa_output_ready),
        .flush                (flush),
        .weights_ready        (weights_ready),
        .err_orphan           (err_orphan)
    );

    // Reference model: queue of tags, rows seen, ready flag per array.
    logic [EB-1:0] q [NA][$];
    int rows_m [NA];
    bit rdy_m [NA];
    int rr_m;
    bit err_m;
    bit ov_auto;
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int a = 0; a < NA; a++) begin
            q[a].delete();
            rows_m[a] = 0;
            rdy_m[a]  = 0;
        end
        rr_m  = 0;
        err_m = 0;
    endtask

    task automatic set_sb(input bit v, input bit w, input int a,
                          input int d);
        bus.sb_valid  = v;
        bus.sb_weight = w;
        bus.sb_array  = SB'(a);
        bus.sb_vdst   = EB'(d);
    endtask

    task automatic cyc();
        int sel, g, idx;
        bit e_rdy, fire;
        logic [NA-1:0] e_w, e_i, e_or, e_wr, orph;
        logic [EB-1:0] e_dst;
        logic [DW-1:0] e_psum;
        veg_vdata1 = {$urandom, $urandom};
        veg_vdata2 = {$urandom, $urandom};
        for (int a = 0; a < NA; a++)
            sa_array_output[a*DW +: DW] = {$urandom, $urandom};
        if (!nRST) model_reset();
        if (ov_auto)
            for (int a = 0; a < NA; a++) sa_out_valid[a] = (q[a].size() > 0);
        @(negedge CLK);
        sel   = int'(bus.sb_array);
        e_rdy = 0;
        if (nRST && !flush && sel < NA)
            e_rdy = bus.sb_weight ? (q[sel].size() == 0)
                  : (rdy_m[sel] && q[sel].size() < TD
                     && sa_fifo_has_space[sel]);
        fire = bus.sb_valid && e_rdy;
        e_w = '0;
        e_i = '0;
        if (fire && bus.sb_weight) e_w[sel] = 1'b1;
        if (fire && !bus.sb_weight) e_i[sel] = 1'b1;
        g = -1;
        if (!flush)
            for (int k = 0; k < NA; k++) begin
                idx = (rr_m + k) % NA;
                if (g < 0 && sa_out_valid[idx] && q[idx].size() > 0) g = idx;
            end
        e_dst  = '0;
        e_psum = '0;
        e_or   = '0;
        if (g >= 0) begin
            e_dst  = q[g][0];
            e_psum = sa_array_output[g*DW +: DW];
            if (bus.wb_output_ready) e_or[g] = 1'b1;
        end
        for (int a = 0; a < NA; a++) begin
            e_wr[a] = rdy_m[a];
            orph[a] = sa_out_valid[a] && q[a].size() == 0;
        end
        check("sb_ready", bus.sb_ready, e_rdy);
        check("weight_en", sa_weight_en, e_w);
        check("input_en", sa_input_en, e_i);
        check("partial_en", sa_partial_en, e_i);
        check("wb_valid", bus.wb_valid, g >= 0);
        check("wb_wbdst", bus.wb_wbdst, e_dst);
        check("wb_array", bus.wb_array, (g >= 0) ? g : 0);
        check("wb_psum", bus.wb_psum, e_psum);
        check("out_ready", sa_output_ready, e_or);
        check("weights_ready", weights_ready, e_wr);
        check("err_orphan", err_orphan, err_m);
        check("sa_flush", sa_flush, nRST && flush);
        check("array_in", sa_array_in, veg_vdata1);
        @(posedge CLK);
        if (nRST) begin
            if (orph != 0) err_m = 1;
            if (flush) begin
                for (int a = 0; a < NA; a++) begin
                    q[a].delete();
                    rows_m[a] = 0;
                    rdy_m[a]  = 0;
                end
            end else begin
                if (e_or != 0) begin
                    void'(q[g].pop_front());
                    rr_m = (g + 1) % NA;
                end
                if (fire && bus.sb_weight) begin
                    rows_m[sel]++;
                    rdy_m[sel] = 0;
                    if (rows_m[sel] == AD) begin
                        rdy_m[sel]  = 1;
                        rows_m[sel] = 0;
                    end
                end else if (fire) begin
                    q[sel].push_back(bus.sb_vdst);
                end
            end
        end
        #1;
    endtask

    task automatic drain();
        set_sb(0, 0, 0, 0);
        ov_auto = 1;
        bus.wb_output_ready = 1;
        for (int k = 0; k < 80; k++)
            if (q[0].size() + q[1].size() > 0) cyc();
        check("drained", q[0].size() + q[1].size(), 0);
    endtask

    initial begin
        set_sb(1, 1, 0, 0);
        bus.wb_output_ready = 0;
        sa_fifo_has_space = '1;
        sa_out_valid = '0;
        sa_array_output = '0;
        veg_vdata1 = '0;
        veg_vdata2 = '0;
        flush = 0;
        ov_auto = 0;
        model_reset();
        repeat (3) cyc();
        nRST = 1;

        set_sb(1, 0, 0, 7);
        repeat (2) cyc();
        set_sb(1, 1, 0, 0);
        repeat (AD) cyc();
        set_sb(1, 0, 0, 7);
        cyc();

        set_sb(1, 1, 1, 0);
        repeat (AD) cyc();
        set_sb(1, 0, 1, 5);
        cyc();
        set_sb(1, 0, 1, 9);
        cyc();
        set_sb(1, 0, 1, 12);
        cyc();
        set_sb(0, 0, 0, 0);
        repeat (2) cyc();
        bus.wb_output_ready = 1;
        sa_out_valid = 2'b10;
        repeat (3) cyc();
        sa_out_valid = '0;

        for (int k = 0; k < 6; k++) begin
            set_sb(1, 0, k % 2, 20 + k);
            cyc();
        end
        set_sb(0, 0, 0, 0);
        ov_auto = 1;
        repeat (2) cyc();
        bus.wb_output_ready = 0;
        repeat (2) cyc();
        drain();
        ov_auto = 0;
        sa_out_valid = '0;

        for (int k = 0; k < TD; k++) begin
            set_sb(1, 0, 0, 100 + k);
            cyc();
        end
        cyc();
        set_sb(1, 0, 1, 77);
        cyc();
        set_sb(0, 0, 0, 0);
        sa_out_valid = 2'b01;
        cyc();
        set_sb(1, 0, 0, 200);
        cyc();
        sa_out_valid = '0;
        cyc();
        drain();

        ov_auto = 0;
        sa_out_valid = '0;
        set_sb(1, 0, 0, 30);
        cyc();
        set_sb(1, 0, 0, 31);
        cyc();
        set_sb(1, 1, 0, 0);
        repeat (2) cyc();
        ov_auto = 1;
        repeat (3) cyc();
        set_sb(0, 0, 0, 0);
        cyc();

        set_sb(1, 1, 0, 0);
        cyc();
        set_sb(1, 0, 1, 40);
        cyc();
        set_sb(1, 0, 1, 41);
        cyc();
        flush = 1;
        cyc();
        flush = 0;
        ov_auto = 0;
        sa_out_valid = '0;
        set_sb(0, 0, 0, 0);
        cyc();
        sa_out_valid = 2'b10;
        cyc();
        sa_out_valid = '0;
        repeat (3) cyc();

        for (int k = 0; k < 800; k++) begin
            set_sb($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   int'($urandom_range(0, NA - 1)), int'($urandom_range(0, 255)));
            sa_fifo_has_space = ($urandom_range(0, 7) != 0) ? '1 : NA'($urandom);
            bus.wb_output_ready = $urandom_range(0, 3) != 0;
            ov_auto = $urandom_range(0, 31) != 0;
            if (!ov_auto) sa_out_valid = NA'($urandom);
            flush = $urandom_range(0, 40) == 0;
            nRST = $urandom_range(0, 120) != 0;
            cyc();
        end

        flush = 0;
        nRST = 0;
        cyc();
        nRST = 1;
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
